// File: rtl/dm_responder.sv
// Word-organised data RAM behind a req/ready handshake with WAIT_CYCLES stall cycles per access.
// Define DM_BYTE_LANE_EN to make stores honour the be byte enables; otherwise stores write full words.
module dm_responder #(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  be,
   output logic        busy,
   output logic        ready,
   output logic [31:0] rdata,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam logic [7:0] WC = 8'(WAIT_CYCLES);

   state_t      state;
   logic [7:0]  cnt;
   logic        we_q;
   logic [31:0] addr_q, wdata_q;
   logic [3:0]  be_q;

   logic [31:0] mem [0:(1<<ADDR_W)-1];

   logic              a_we, a_err, enter_resp;
   logic [31:0]       a_addr, a_wdata, wmask;
   logic [3:0]        a_be;
   logic [ADDR_W-1:0] idx;

   // With zero wait states the access happens on the accept edge itself, so the live
   // inputs are used in IDLE and the latched copy everywhere else.
   always_comb begin
      a_we       = (state == IDLE) ? we    : we_q;
      a_addr     = (state == IDLE) ? addr  : addr_q;
      a_wdata    = (state == IDLE) ? wdata : wdata_q;
      a_be       = (state == IDLE) ? be    : be_q;
      idx        = a_addr[ADDR_W+1:2];
      a_err      = (a_addr[1:0] != 2'b00) || ((a_addr >> (ADDR_W + 2)) != 32'd0);
      enter_resp = ((state == IDLE) && req && (WAIT_CYCLES == 0)) ||
                   ((state == WAIT) && (cnt == 8'd0));
   end

`ifdef DM_BYTE_LANE_EN
   assign wmask = {{8{a_be[3]}}, {8{a_be[2]}}, {8{a_be[1]}}, {8{a_be[0]}}};
`else
   logic unused_be;
   assign unused_be = ^a_be;
   assign wmask     = 32'hFFFF_FFFF;
`endif

   // RAM has no reset; the reset gate keeps a store from landing while reset is held.
   always_ff @(posedge clock) begin
      if (!reset && enter_resp && a_we && !a_err)
         mem[idx] <= (mem[idx] & ~wmask) | (a_wdata & wmask);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= 8'd0;
         busy    <= 1'b0;
         ready   <= 1'b0;
         rdata   <= 32'd0;
         err     <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         be_q    <= 4'd0;
      end else begin
         ready <= 1'b0;
         case (state)
            IDLE: if (req) begin
               we_q    <= we;
               addr_q  <= addr;
               wdata_q <= wdata;
               be_q    <= be;
               busy    <= 1'b1;
               if (WC == 8'd0) begin
                  state <= RESP;
                  ready <= 1'b1;
               end else begin
                  state <= WAIT;
                  cnt   <= WC - 8'd1;
               end
            end
            WAIT: if (cnt == 8'd0) begin
               state <= RESP;
               ready <= 1'b1;
            end else begin
               cnt <= cnt - 8'd1;
            end
            RESP: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
         if (enter_resp) begin
            err <= a_err;
            if (a_err)     rdata <= 32'd0;
            else if (!a_we) rdata <= mem[idx];
         end
      end
   end

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: vector table on a 2-wait-state instance plus
// hand sequences for reset abort, mid-transaction input changes and zero-wait back-to-back.
module tb_dm_responder;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req = 1'b0, we = 1'b0;
   logic [31:0] addr = '0, wdata = '0;
   logic [3:0]  be = '0;
   logic        busy, ready, err;
   logic [31:0] rdata;

   logic        req0 = 1'b0, we0 = 1'b0;
   logic [31:0] addr0 = '0, wdata0 = '0;
   logic [3:0]  be0 = 4'hF;
   logic        busy0, ready0, err0;
   logic [31:0] rdata0;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clock = ~clock;

   dm_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut (
      .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
      .busy(busy), .ready(ready), .rdata(rdata), .err(err));

   dm_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
      .clock(clock), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0), .be(be0),
      .busy(busy0), .ready(ready0), .rdata(rdata0), .err(err0));

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // One transaction on the 2-wait-state instance; optionally scrambles inputs while busy.
   task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                      input bit scramble, output logic [31:0] rd, output logic e);
      int lat;
      @(negedge clock);
      req = 1'b1; we = w; addr = a; wdata = d; be = b;
      @(posedge clock); #1;
      check("busy_at_accept", {31'd0, busy}, 32'd1);
      lat = 0;
      while (!ready && lat < 20) begin
         @(negedge clock);
         if (scramble) begin
            we = ~w; addr = 32'h13; wdata = ~d; be = 4'h0;
         end else begin
            req = 1'b0;
         end
         @(posedge clock); #1;
         lat++;
      end
      check("latency", lat, 2);
      rd = rdata;
      e  = err;
      @(negedge clock);
      req = 1'b0;
      @(posedge clock); #1;
      check("ready_one_cycle", {30'd0, ready, busy}, 32'd0);
   endtask

   vec_t vecs[$];
   logic [31:0] rd;
   logic        e;
   logic        exp_rdy;

   initial begin
      vecs.push_back('{1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 32'h0,        1'b0});
      vecs.push_back('{1'b0, 32'h10,       32'h0,        4'hF, 32'hDEADBEEF, 1'b0});
      vecs.push_back('{1'b1, 32'h20,       32'h12345678, 4'hF, 32'hDEADBEEF, 1'b0});
      vecs.push_back('{1'b1, 32'h0,        32'h00000001, 4'hF, 32'hDEADBEEF, 1'b0});
      vecs.push_back('{1'b0, 32'h13,       32'h0,        4'hF, 32'h0,        1'b1});
      vecs.push_back('{1'b0, 32'h1000,     32'h0,        4'hF, 32'h0,        1'b1});
      vecs.push_back('{1'b1, 32'h1000,     32'hCAFEF00D, 4'hF, 32'h0,        1'b1});
      vecs.push_back('{1'b1, 32'h12,       32'hCAFEF00D, 4'hF, 32'h0,        1'b1});
      vecs.push_back('{1'b1, 32'h8000_0000, 32'hCAFEF00D, 4'hF, 32'h0,       1'b1});
      vecs.push_back('{1'b0, 32'h0,        32'h0,        4'hF, 32'h00000001, 1'b0});
      vecs.push_back('{1'b0, 32'h10,       32'h0,        4'hF, 32'hDEADBEEF, 1'b0});
      vecs.push_back('{1'b1, 32'hFFC,      32'h0F0F0F0F, 4'hF, 32'hDEADBEEF, 1'b0});
      vecs.push_back('{1'b0, 32'hFFC,      32'h0,        4'hF, 32'h0F0F0F0F, 1'b0});
      vecs.push_back('{1'b1, 32'h40,       32'h11223344, 4'hF, 32'h0F0F0F0F, 1'b0});
      vecs.push_back('{1'b1, 32'h40,       32'hAABBCCDD, 4'h5, 32'h0F0F0F0F, 1'b0});
`ifdef DM_BYTE_LANE_EN
      vecs.push_back('{1'b0, 32'h40,       32'h0,        4'h0, 32'h11BB33DD, 1'b0});
`else
      vecs.push_back('{1'b0, 32'h40,       32'h0,        4'h0, 32'hAABBCCDD, 1'b0});
`endif
      vecs.push_back('{1'b1, 32'h44,       32'h55667788, 4'hF, 32'h0,        1'b0});
      vecs.push_back('{1'b1, 32'h44,       32'h99999999, 4'h0, 32'h0,        1'b0});
`ifdef DM_BYTE_LANE_EN
      vecs.push_back('{1'b0, 32'h44,       32'h0,        4'hF, 32'h55667788, 1'b0});
`else
      vecs.push_back('{1'b0, 32'h44,       32'h0,        4'hF, 32'h99999999, 1'b0});
`endif
      // Store rdata expectations depend on the preceding load, so fix up the held values.
      vecs[16].exp_rdata = vecs[15].exp_rdata;
      vecs[17].exp_rdata = vecs[15].exp_rdata;

      #1;
      check("reset_outputs", {rdata[30:0], busy, ready, err} ^ {rdata[31], 34'd0} == 35'd0 ? 32'd0 : 32'd1, 32'd0);
      check("reset_rdata", rdata, 32'd0);
      check("reset_flags", {29'd0, busy, ready, err}, 32'd0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;

      foreach (vecs[i]) begin
         txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, 1'b0, rd, e);
         check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
         check($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
      end

      // Reset in the middle of a store's WAIT phase: store must be abandoned.
      @(negedge clock);
      req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hBADBAD00; be = 4'hF;
      @(posedge clock); #1;
      check("abort_busy", {31'd0, busy}, 32'd1);
      @(negedge clock);
      req = 1'b0;
      reset = 1'b1;
      #1;
      check("abort_flags", {29'd0, busy, ready, err}, 32'd0);
      check("abort_rdata", rdata, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      txn(1'b0, 32'h20, 32'h0, 4'hF, 1'b0, rd, e);
      check("abort_word_kept", rd, 32'h12345678);

      // Inputs changed while busy must not affect the transaction.
      txn(1'b1, 32'h50, 32'h0BADF00D, 4'hF, 1'b1, rd, e);
      check("scramble_store_err", {31'd0, e}, 32'd0);
      txn(1'b0, 32'h50, 32'h0, 4'hF, 1'b1, rd, e);
      check("scramble_load_rdata", rd, 32'h0BADF00D);
      check("scramble_load_err", {31'd0, e}, 32'd0);

      // Zero-wait instance: response in the cycle right after accept.
      @(negedge clock);
      req0 = 1'b1; we0 = 1'b1; addr0 = 32'h8; wdata0 = 32'h5A5A5A5A;
      @(posedge clock); #1;
      check("w0_store_ready", {30'd0, ready0, err0}, 32'd2);
      check("w0_store_rdata", rdata0, 32'd0);
      @(negedge clock);
      we0 = 1'b0;
      @(posedge clock); #1;
      check("w0_resp_ignores_req", {31'd0, ready0}, 32'd0);
      // req held high: accept on every second edge, ready alternates.
      for (int k = 0; k < 10; k++) begin
         @(posedge clock); #1;
         exp_rdy = ((k % 2) == 0);
         check($sformatf("w0_ready_edge%0d", k), {31'd0, ready0}, {31'd0, exp_rdy});
         if (exp_rdy) check($sformatf("w0_rdata_edge%0d", k), rdata0, 32'h5A5A5A5A);
      end
      @(negedge clock);
      req0 = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
